// File: rtl/boot_loader.sv
// Streams instruction words into the inst_rom write port, appends a zero terminator,
// then starts the CPU with a timed reset release. Optional BOOT_CHECKSUM_EN adds a load checksum.
module boot_loader #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned ADDR_STEP   = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_last,
`ifdef BOOT_CHECKSUM_EN
    input  logic [DATA_W-1:0]          expected_sum,
`endif
    output logic                       rom_we,
    output logic [ADDR_W-1:0]          rom_addr,
    output logic [DATA_W-1:0]          rom_data,
    output logic                       cpu_go,
    output logic                       cpu_reset,
    output logic [$clog2(DEPTH+1)-1:0] words_loaded,
    output logic                       done,
    output logic                       error
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    // Input handshake: a word transfers on any rising edge where in_valid and in_ready are
    // both high; in_data/in_last are only looked at on that edge.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TERM,
        HOLD,
        RUN,
        ERR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic                start_load;
    logic                write_term;
    logic                sum_ok;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [HOLD_W-1:0]   hold_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        cpu_go     = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        accept     = 1'b0;
        start_load = 1'b0;
        write_term = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    start_load = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // The last slot is reserved for the terminator word.
                in_ready = (words_loaded < CNT_W'(DEPTH - 1));
                accept   = in_valid && in_ready;
                if (accept && in_last) begin
                    state_next = TERM;
                end else if (in_valid && !in_ready) begin
                    state_next = ERR;
                end
            end
            TERM: begin
                write_term = 1'b1;
                state_next = sum_ok ? HOLD : ERR;
            end
            HOLD: begin
                cpu_go = 1'b1;
                if (hold_cnt <= HOLD_W'(1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                cpu_go    = 1'b1;
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (load_start) begin
                    start_load = 1'b1;
                    state_next = LOAD;
                end
            end
            ERR: begin
                error = 1'b1;
                if (load_start) begin
                    start_load = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write port is registered: a word accepted on one edge appears on the ROM port the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_we       <= 1'b0;
            rom_addr     <= ADDR_W'(BASE_ADDR);
            rom_data     <= '0;
            wr_ptr       <= ADDR_W'(BASE_ADDR);
            words_loaded <= '0;
            hold_cnt     <= '0;
        end else begin
            rom_we <= 1'b0;
            if (start_load) begin
                wr_ptr       <= ADDR_W'(BASE_ADDR);
                words_loaded <= '0;
            end
            if (accept) begin
                rom_we       <= 1'b1;
                rom_addr     <= wr_ptr;
                rom_data     <= in_data;
                wr_ptr       <= wr_ptr + ADDR_W'(ADDR_STEP);
                words_loaded <= words_loaded + CNT_W'(1);
            end
            if (write_term) begin
                rom_we   <= 1'b1;
                rom_addr <= wr_ptr;
                rom_data <= '0;
                hold_cnt <= HOLD_W'(HOLD_CYCLES);
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (start_load) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum + in_data;
        end
    end

    assign sum_ok = (sum == expected_sum);
`else
    assign sum_ok = 1'b1;
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a row table for the main load flows plus hand-written
// overflow, async-reset and (with BOOT_CHECKSUM_EN) checksum sequences.
module tb_boot_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] in_data = '0;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] expected_sum = '0;
`endif

    // Main instance, default DEPTH=32
    logic        b_in_ready, b_rom_we, b_cpu_go, b_cpu_reset, b_done, b_error;
    logic [31:0] b_rom_addr, b_rom_data;
    logic [5:0]  b_words_loaded;
    // Small instance, DEPTH=4, for overflow
    logic        s_in_ready, s_rom_we, s_cpu_go, s_cpu_reset, s_done, s_error;
    logic [31:0] s_rom_addr, s_rom_data;
    logic [2:0]  s_words_loaded;

    boot_loader u_big (
        .clk(clk), .reset(reset), .load_start(load_start),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
`ifdef BOOT_CHECKSUM_EN
        .expected_sum(expected_sum),
`endif
        .rom_we(b_rom_we), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
        .cpu_go(b_cpu_go), .cpu_reset(b_cpu_reset), .words_loaded(b_words_loaded),
        .done(b_done), .error(b_error)
    );

    boot_loader #(.DEPTH(4)) u_small (
        .clk(clk), .reset(reset), .load_start(load_start),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
`ifdef BOOT_CHECKSUM_EN
        .expected_sum(expected_sum),
`endif
        .rom_we(s_rom_we), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
        .cpu_go(s_cpu_go), .cpu_reset(s_cpu_reset), .words_loaded(s_words_loaded),
        .done(s_done), .error(s_error)
    );

    int checks = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ls, v, l;
        logic [31:0] d, sum;
        logic        we;
        logic [31:0] addr, data;
        logic        rdy, go, rst, dn, err;
        logic [5:0]  wl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ls, input logic v, input logic [31:0] d, input logic l,
                       input logic [31:0] sum, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic rdy, input logic go,
                       input logic rst, input logic dn, input logic err, input logic [5:0] wl);
        vec_t r;
        r.ls = ls; r.v = v; r.d = d; r.l = l; r.sum = sum;
        r.we = we; r.addr = addr; r.data = data;
        r.rdy = rdy; r.go = go; r.rst = rst; r.dn = dn; r.err = err; r.wl = wl;
        vecs.push_back(r);
    endtask

    // Drive on the falling edge, let one rising edge pass, return on the next falling edge.
    task automatic cyc(input logic ls, input logic v, input logic [31:0] d, input logic l);
        load_start = ls;
        in_valid   = v;
        in_data    = d;
        in_last    = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " rom_we"}, 32'(b_rom_we), 32'd0);
        chk({tag, " rom_addr"}, b_rom_addr, 32'd0);
        chk({tag, " rom_data"}, b_rom_data, 32'd0);
        chk({tag, " in_ready"}, 32'(b_in_ready), 32'd0);
        chk({tag, " cpu_go"}, 32'(b_cpu_go), 32'd0);
        chk({tag, " cpu_reset"}, 32'(b_cpu_reset), 32'd1);
        chk({tag, " words_loaded"}, 32'(b_words_loaded), 32'd0);
        chk({tag, " done"}, 32'(b_done), 32'd0);
        chk({tag, " error"}, 32'(b_error), 32'd0);
        chk({tag, " small error"}, 32'(s_error), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s1, s2, s3;
        s1 = 32'h00A08359;  // 0x00500093 + 0x00300113 + 0x002081B3
        s2 = 32'hDEADBEEF;
        s3 = 32'h000000AA;  // 0x11 + 0x22 + 0x33 + 0x44

        // Three-word load, one word per cycle
        add(1, 0, 32'h0, 0, s1,          0, 32'd0,  32'h0,          1, 0, 1, 0, 0, 6'd0);
        add(0, 1, 32'h00500093, 0, s1,   1, 32'd0,  32'h00500093,   1, 0, 1, 0, 0, 6'd1);
        add(0, 1, 32'h00300113, 0, s1,   1, 32'd4,  32'h00300113,   1, 0, 1, 0, 0, 6'd2);
        add(0, 1, 32'h002081B3, 1, s1,   1, 32'd8,  32'h002081B3,   0, 0, 1, 0, 0, 6'd3);
        add(0, 0, 32'h0, 0, s1,          1, 32'd12, 32'h0,          0, 1, 1, 0, 0, 6'd3);
        add(0, 0, 32'h0, 0, s1,          0, 32'd0,  32'h0,          0, 1, 1, 0, 0, 6'd3);
        add(0, 0, 32'h0, 0, s1,          0, 32'd0,  32'h0,          0, 1, 0, 1, 0, 6'd3);
        add(0, 0, 32'h0, 0, s1,          0, 32'd0,  32'h0,          0, 1, 0, 1, 0, 6'd3);
        // Restart from RUN, single-word load back at address 0
        add(1, 0, 32'h0, 0, s2,          0, 32'd0,  32'h0,          1, 0, 1, 0, 0, 6'd0);
        add(0, 1, 32'hDEADBEEF, 1, s2,   1, 32'd0,  32'hDEADBEEF,   0, 0, 1, 0, 0, 6'd1);
        add(0, 0, 32'h0, 0, s2,          1, 32'd4,  32'h0,          0, 1, 1, 0, 0, 6'd1);
        add(0, 0, 32'h0, 0, s2,          0, 32'd0,  32'h0,          0, 1, 1, 0, 0, 6'd1);
        add(0, 0, 32'h0, 0, s2,          0, 32'd0,  32'h0,          0, 1, 0, 1, 0, 6'd1);
        // Gapped stream; in_last without in_valid and load_start during LOAD are ignored
        add(1, 0, 32'h0, 0, s3,          0, 32'd0,  32'h0,          1, 0, 1, 0, 0, 6'd0);
        add(0, 1, 32'h11, 0, s3,         1, 32'd0,  32'h11,         1, 0, 1, 0, 0, 6'd1);
        add(0, 0, 32'h0, 1, s3,          0, 32'd0,  32'h0,          1, 0, 1, 0, 0, 6'd1);
        add(0, 1, 32'h22, 0, s3,         1, 32'd4,  32'h22,         1, 0, 1, 0, 0, 6'd2);
        add(1, 0, 32'h0, 0, s3,          0, 32'd0,  32'h0,          1, 0, 1, 0, 0, 6'd2);
        add(0, 1, 32'h33, 0, s3,         1, 32'd8,  32'h33,         1, 0, 1, 0, 0, 6'd3);
        add(0, 0, 32'h0, 0, s3,          0, 32'd0,  32'h0,          1, 0, 1, 0, 0, 6'd3);
        add(0, 1, 32'h44, 1, s3,         1, 32'd12, 32'h44,         0, 0, 1, 0, 0, 6'd4);
        add(0, 0, 32'h0, 0, s3,          1, 32'd16, 32'h0,          0, 1, 1, 0, 0, 6'd4);
        add(0, 0, 32'h0, 0, s3,          0, 32'd0,  32'h0,          0, 1, 1, 0, 0, 6'd4);
        add(0, 0, 32'h0, 0, s3,          0, 32'd0,  32'h0,          0, 1, 0, 1, 0, 6'd4);

        // Reset values while reset is held
        @(negedge clk);
        chk_reset_values("in_reset");
        reset = 1'b1;
        @(negedge clk);
        chk_reset_values("idle");

        for (int i = 0; i < vecs.size(); i++) begin
`ifdef BOOT_CHECKSUM_EN
            expected_sum = vecs[i].sum;
`endif
            cyc(vecs[i].ls, vecs[i].v, vecs[i].d, vecs[i].l);
            chk($sformatf("row%0d rom_we", i), 32'(b_rom_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("row%0d rom_addr", i), b_rom_addr, vecs[i].addr);
                chk($sformatf("row%0d rom_data", i), b_rom_data, vecs[i].data);
            end
            chk($sformatf("row%0d in_ready", i), 32'(b_in_ready), 32'(vecs[i].rdy));
            chk($sformatf("row%0d cpu_go", i), 32'(b_cpu_go), 32'(vecs[i].go));
            chk($sformatf("row%0d cpu_reset", i), 32'(b_cpu_reset), 32'(vecs[i].rst));
            chk($sformatf("row%0d done", i), 32'(b_done), 32'(vecs[i].dn));
            chk($sformatf("row%0d error", i), 32'(b_error), 32'(vecs[i].err));
            chk($sformatf("row%0d words_loaded", i), 32'(b_words_loaded), 32'(vecs[i].wl));
        end

        // Overflow on the DEPTH=4 instance: three words fit, the fourth is refused
        cyc(1, 0, 32'h0, 0);
        chk("ovf start in_ready", 32'(s_in_ready), 32'd1);
        chk("ovf start error", 32'(s_error), 32'd0);
        cyc(0, 1, 32'hA0, 0);
        chk("ovf w0 rom_we", 32'(s_rom_we), 32'd1);
        chk("ovf w0 rom_addr", s_rom_addr, 32'd0);
        chk("ovf w0 rom_data", s_rom_data, 32'hA0);
        cyc(0, 1, 32'hA1, 0);
        chk("ovf w1 rom_addr", s_rom_addr, 32'd4);
        cyc(0, 1, 32'hA2, 0);
        chk("ovf w2 rom_we", 32'(s_rom_we), 32'd1);
        chk("ovf w2 rom_addr", s_rom_addr, 32'd8);
        chk("ovf full in_ready", 32'(s_in_ready), 32'd0);
        chk("ovf full error", 32'(s_error), 32'd0);
        cyc(0, 1, 32'hA3, 0);
        chk("ovf error", 32'(s_error), 32'd1);
        chk("ovf cpu_go", 32'(s_cpu_go), 32'd0);
        chk("ovf cpu_reset", 32'(s_cpu_reset), 32'd1);
        chk("ovf no write", 32'(s_rom_we), 32'd0);
        chk("ovf words_loaded", 32'(s_words_loaded), 32'd3);
        chk("big w3 rom_addr", b_rom_addr, 32'd12);
        chk("big w3 words_loaded", 32'(b_words_loaded), 32'd4);
        chk("big w3 rom_we", 32'(b_rom_we), 32'd1);

        // Asynchronous reset mid-load, checked before any clock edge
        in_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk_reset_values("async_reset");
        @(negedge clk);
        reset = 1'b1;

`ifdef BOOT_CHECKSUM_EN
        expected_sum = 32'h3;
        cyc(1, 0, 32'h0, 0);
        cyc(0, 1, 32'h1, 0);
        cyc(0, 1, 32'h2, 1);
        cyc(0, 0, 32'h0, 0);
        chk("sum ok term rom_addr", b_rom_addr, 32'd8);
        cyc(0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 0);
        chk("sum ok done", 32'(b_done), 32'd1);
        chk("sum ok error", 32'(b_error), 32'd0);
        expected_sum = 32'h4;
        cyc(1, 0, 32'h0, 0);
        cyc(0, 1, 32'h1, 0);
        cyc(0, 1, 32'h2, 1);
        cyc(0, 0, 32'h0, 0);
        chk("sum bad error", 32'(b_error), 32'd1);
        chk("sum bad cpu_go", 32'(b_cpu_go), 32'd0);
        chk("sum bad term rom_we", 32'(b_rom_we), 32'd1);
        chk("sum bad term rom_addr", b_rom_addr, 32'd8);
        chk("sum bad term rom_data", b_rom_data, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
